odd_sequence_checker: RTL and testbench
=======================================

ODD_SEQUENCE_CHECKER -- requirements
Module: odd_sequence_checker

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, sampled on the rising edge of clk.
REQ-002 Parameter LOCK_N, default 3, SHALL set the number of consecutive matching samples needed to lock (legal range 1..7).
REQ-003 Parameter MISS_N, default 2, SHALL set the number of consecutive mismatches in LOCKED that drop lock (legal range 1..7).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 valid  input  1  count and Y are sampled this cycle when high; all other cycles are ignored.
REQ-007 count  input  4  observed odd up/down counter value.
REQ-008 Y  input  1  direction that applies to the step after this sample (1 = up by 2, 0 = down by 2).
REQ-009 locked  output  1  high while the FSM is in LOCKED.
REQ-010 err  output  1  one-cycle pulse per mismatching sample in LOCKED.
REQ-011 err_count  output  8  total LOCKED mismatches since reset, saturating.
REQ-012 expected  output  4  next value the checker predicts.
REQ-013 dir  output  1  Y captured at the last accepted sample.

Function
REQ-014 nxt(v,d) SHALL equal (v+2) mod 16 when d=1 and (v-2) mod 16 when d=0; the wraps are 15->1 up and 1->15 down.
REQ-015 All outputs SHALL be registered, so the response to a valid sample appears the cycle after it is sampled.
REQ-016 FSM states SHALL be HUNT, CONFIRM and LOCKED, and the FSM SHALL change state only on valid cycles.
REQ-017 In HUNT, a valid sample with count[0]=1 SHALL set expected=nxt(count,Y) and dir=Y, set match_cnt=1, and move to CONFIRM (or directly to LOCKED if LOCK_N=1).
REQ-018 In HUNT, a valid sample with even count SHALL be ignored: no state change, no err, expected unchanged.
REQ-019 In CONFIRM, a sample with count==expected SHALL set expected=nxt(count,Y) and increment match_cnt; when match_cnt reaches LOCK_N the FSM SHALL go to LOCKED.
REQ-020 In CONFIRM, a mismatch SHALL restart the HUNT evaluation on the same sample: if odd, reload as in REQ-017 with match_cnt=1; if even, go to HUNT. No err is raised.
REQ-021 In LOCKED, a match SHALL set expected=nxt(count,Y), set dir=Y and clear miss_cnt.
REQ-022 In LOCKED, a mismatch SHALL pulse err for exactly one cycle, increment err_count (holding at 255), set expected=nxt(expected,dir) (flywheel), and increment miss_cnt.
REQ-023 When miss_cnt reaches MISS_N, the FSM SHALL go to HUNT, drop locked on that same update, and clear miss_cnt.
REQ-024 A change of Y SHALL take effect from the sample where it is seen; for example, count=7 with Y switching 1->0 gives expected=5, and this SHALL NOT be an error.
REQ-025 Non-valid cycles SHALL hold every register, and err SHALL be 0 on them.
REQ-026 Back-to-back valid cycles SHALL be supported at full rate.

Reset
REQ-027 Reset SHALL take priority over valid.
REQ-028 On reset, the block SHALL go to HUNT with locked=0, err=0, err_count=0, expected=4'b0001, dir=1, and match_cnt and miss_cnt cleared.
REQ-029 A reset asserted mid-stream (any state) SHALL discard that cycle's sample, and the block SHALL resume in HUNT on the first valid cycle after reset deasserts.

Verification
REQ-030 Clean up-count, valid every cycle, Y=1, count 1,3,5,...,15,1: locked=1 one cycle after the 3rd sample (count=5); err stays 0; after count=15, expected=1.
REQ-031 Direction flip while locked, up 1,3,5,7 then Y=0 at count=7, then 5,3,1,15: no err pulses; dir=0 after the 7 sample; 1->15 wrap accepted.
REQ-032 Single glitch while locked: expected=9 but 4'b1011 is sampled, then 11 arrives. err pulses once, err_count=1, locked stays 1, and the next sample (11) matches via the flywheel.
REQ-033 Two consecutive mismatches while locked: err pulses twice, err_count=2, locked=0 after the second, FSM is in HUNT.
REQ-034 Even values 4'b0100 and 4'b0110 in HUNT, followed by 3: no err, stays unlocked; 3 starts CONFIRM with expected=5.
REQ-035 err_count saturation and reset: 300 forced mismatches with re-locks in between leave err_count=255; reset asserted while locked gives locked=0, err_count=0 and expected=1 on the next cycle.

Source files
------------

// File: rtl/odd_sequence_checker.sv
// Tracks an odd up/down-by-2 counter: hunts for an odd value, confirms LOCK_N matches, then flags mismatches.
// All outputs registered (one cycle after the sample); idle cycles hold state and never pulse err.
module odd_sequence_checker #(
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned MISS_N = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [3:0] count,
    input  logic       Y,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [3:0] expected,
    output logic       dir
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_TGT = 3'(LOCK_N);
    localparam logic [2:0] MISS_TGT = 3'(MISS_N);

    function automatic logic [3:0] nxt(input logic [3:0] v, input logic d);
        return d ? (v + 4'd2) : (v - 4'd2);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] expected_q, expected_d;
    logic       dir_q, dir_d;
    logic [2:0] match_cnt_q, match_cnt_d;
    logic [2:0] miss_cnt_q, miss_cnt_d;
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       locked_q, locked_d;
    logic       acquire;
    logic       hit;

    assign hit = (count == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        dir_d       = dir_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        acquire     = 1'b0;

        if (valid) begin
            case (state_q)
                HUNT: begin
                    acquire = count[0];
                end
                CONFIRM: begin
                    if (hit) begin
                        expected_d  = nxt(count, Y);
                        dir_d       = Y;
                        match_cnt_d = match_cnt_q + 3'd1;
                        if ((match_cnt_q + 3'd1) >= LOCK_TGT) begin
                            state_d    = LOCKED;
                            miss_cnt_d = 3'd0;
                        end
                    end else if (count[0]) begin
                        acquire = 1'b1;
                    end else begin
                        state_d     = HUNT;
                        match_cnt_d = 3'd0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        expected_d = nxt(count, Y);
                        dir_d      = Y;
                        miss_cnt_d = 3'd0;
                    end else begin
                        // Flywheel: keep predicting along the last trusted direction.
                        err_d      = 1'b1;
                        expected_d = nxt(expected_q, dir_q);
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        if ((miss_cnt_q + 3'd1) >= MISS_TGT) begin
                            state_d     = HUNT;
                            miss_cnt_d  = 3'd0;
                            match_cnt_d = 3'd0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            if (acquire) begin
                expected_d  = nxt(count, Y);
                dir_d       = Y;
                match_cnt_d = 3'd1;
                miss_cnt_d  = 3'd0;
                state_d     = (LOCK_TGT <= 3'd1) ? LOCKED : CONFIRM;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            expected_q  <= 4'b0001;
            dir_q       <= 1'b1;
            match_cnt_q <= 3'd0;
            miss_cnt_q  <= 3'd0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            dir_q       <= dir_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign dir       = dir_q;

endmodule

// File: tb/tb_odd_sequence_checker.sv
// Scoreboard bench: each driven cycle pushes its hand-computed response; the monitor pops one per cycle.
module tb_odd_sequence_checker;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic [7:0] cnt;
        logic [3:0] exp;
        logic       dir;
    } resp_t;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [3:0] count;
    logic       Y;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [3:0] expected;
    logic       dir;

    resp_t exp_q[$];
    string name_q[$];
    int    n_cmp;
    int    n_bad;
    resp_t mon_e;
    resp_t mon_a;
    string mon_nm;
    logic  done;

    odd_sequence_checker #(.LOCK_N(3), .MISS_N(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .count     (count),
        .Y         (Y),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .expected  (expected),
        .dir       (dir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        done = 1'b0;
        #200000;
        if (!done) begin
            $display("FAIL timeout: stimulus did not complete within the wait limit");
            $finish;
        end
    end

    // Drive one cycle and queue the response expected right after its rising edge.
    task automatic cyc(input logic r, input logic v, input logic [3:0] c, input logic y,
                       input logic el, input logic ee, input logic [7:0] ec,
                       input logic [3:0] ex, input logic ed, input string nm);
        resp_t e;
        reset = r;
        valid = v;
        count = c;
        Y     = y;
        e = '{locked: el, err: ee, cnt: ec, exp: ex, dir: ed};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sat8(input int x);
        return (x > 255) ? 8'd255 : 8'(x);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            mon_a  = '{locked: locked, err: err, cnt: err_count, exp: expected, dir: dir};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL %s: got locked=%0b err=%0b err_count=%0d expected=%0d dir=%0b, want locked=%0b err=%0b err_count=%0d expected=%0d dir=%0b",
                         mon_nm, mon_a.locked, mon_a.err, mon_a.cnt, mon_a.exp, mon_a.dir,
                         mon_e.locked, mon_e.err, mon_e.cnt, mon_e.exp, mon_e.dir);
            end
        end
    end

    initial begin
        int c;
        n_cmp = 0;
        n_bad = 0;

        // Clean up-count lock and run through the 15->1 wrap.
        cyc(1, 0, 4'd0,  0, 0, 0, 8'd0, 4'd1,  1, "reset_state");
        n_cmp++;
        if (locked !== 1'b0 || err !== 1'b0 || err_count !== 8'd0 ||
            expected !== 4'd1 || dir !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_direct: locked=%0b err=%0b err_count=%0d expected=%0d dir=%0b",
                     locked, err, err_count, expected, dir);
        end
        cyc(0, 1, 4'd1,  1, 0, 0, 8'd0, 4'd3,  1, "up1_confirm");
        cyc(0, 1, 4'd3,  1, 0, 0, 8'd0, 4'd5,  1, "up3_confirm");
        cyc(0, 1, 4'd5,  1, 1, 0, 8'd0, 4'd7,  1, "up5_lock");
        cyc(0, 0, 4'd10, 0, 1, 0, 8'd0, 4'd7,  1, "idle_hold");
        cyc(0, 1, 4'd7,  1, 1, 0, 8'd0, 4'd9,  1, "up7");
        cyc(0, 1, 4'd9,  1, 1, 0, 8'd0, 4'd11, 1, "up9");
        cyc(0, 1, 4'd11, 1, 1, 0, 8'd0, 4'd13, 1, "up11");
        cyc(0, 1, 4'd13, 1, 1, 0, 8'd0, 4'd15, 1, "up13");
        cyc(0, 1, 4'd15, 1, 1, 0, 8'd0, 4'd1,  1, "up15_wrap");
        cyc(0, 1, 4'd1,  1, 1, 0, 8'd0, 4'd3,  1, "up1_after_wrap");

        // Direction flip at 7 while locked, then the 1->15 down wrap.
        cyc(0, 1, 4'd3,  1, 1, 0, 8'd0, 4'd5,  1, "flip_up3");
        cyc(0, 1, 4'd5,  1, 1, 0, 8'd0, 4'd7,  1, "flip_up5");
        cyc(0, 1, 4'd7,  0, 1, 0, 8'd0, 4'd5,  0, "flip_at7");
        cyc(0, 1, 4'd5,  0, 1, 0, 8'd0, 4'd3,  0, "dn5");
        cyc(0, 1, 4'd3,  0, 1, 0, 8'd0, 4'd1,  0, "dn3");
        cyc(0, 1, 4'd1,  0, 1, 0, 8'd0, 4'd15, 0, "dn1_wrap");
        cyc(0, 1, 4'd15, 0, 1, 0, 8'd0, 4'd13, 0, "dn15");

        // Single glitch recovered by the flywheel.
        cyc(0, 1, 4'd13, 1, 1, 0, 8'd0, 4'd15, 1, "g13");
        cyc(0, 1, 4'd15, 1, 1, 0, 8'd0, 4'd1,  1, "g15");
        cyc(0, 1, 4'd1,  1, 1, 0, 8'd0, 4'd3,  1, "g1");
        cyc(0, 1, 4'd3,  1, 1, 0, 8'd0, 4'd5,  1, "g3");
        cyc(0, 1, 4'd5,  1, 1, 0, 8'd0, 4'd7,  1, "g5");
        cyc(0, 1, 4'd7,  1, 1, 0, 8'd0, 4'd9,  1, "g7");
        cyc(0, 1, 4'd11, 1, 1, 1, 8'd1, 4'd11, 1, "glitch_err");
        cyc(0, 1, 4'd11, 1, 1, 0, 8'd1, 4'd13, 1, "glitch_flywheel");

        // Two consecutive misses drop lock.
        cyc(1, 0, 4'd0,  0, 0, 0, 8'd0, 4'd1,  1, "reset2");
        cyc(0, 1, 4'd1,  1, 0, 0, 8'd0, 4'd3,  1, "m_up1");
        cyc(0, 1, 4'd3,  1, 0, 0, 8'd0, 4'd5,  1, "m_up3");
        cyc(0, 1, 4'd5,  1, 1, 0, 8'd0, 4'd7,  1, "m_lock");
        cyc(0, 1, 4'd11, 1, 1, 1, 8'd1, 4'd9,  1, "miss1");
        cyc(0, 1, 4'd11, 1, 0, 1, 8'd2, 4'd11, 1, "miss2_drop");
        cyc(0, 0, 4'd3,  1, 0, 0, 8'd2, 4'd11, 1, "idle_no_err");

        // Even values ignored in HUNT; CONFIRM reload and fallback to HUNT.
        cyc(0, 1, 4'd4,  1, 0, 0, 8'd2, 4'd11, 1, "hunt_even4");
        cyc(0, 1, 4'd6,  0, 0, 0, 8'd2, 4'd11, 1, "hunt_even6");
        cyc(0, 1, 4'd3,  1, 0, 0, 8'd2, 4'd5,  1, "hunt_odd3");
        cyc(0, 1, 4'd9,  0, 0, 0, 8'd2, 4'd7,  0, "confirm_reload");
        cyc(0, 1, 4'd7,  0, 0, 0, 8'd2, 4'd5,  0, "confirm_match");
        cyc(0, 1, 4'd4,  1, 0, 0, 8'd2, 4'd5,  0, "confirm_even_hunt");
        cyc(0, 1, 4'd5,  0, 0, 0, 8'd2, 4'd3,  0, "dn_hunt5");
        cyc(0, 1, 4'd3,  0, 0, 0, 8'd2, 4'd1,  0, "dn_confirm3");
        cyc(0, 1, 4'd1,  0, 1, 0, 8'd2, 4'd15, 0, "dn_lock1");

        // Saturation: 150 lock/drop rounds, two errors each.
        cyc(1, 0, 4'd0,  0, 0, 0, 8'd0, 4'd1,  1, "reset3");
        c = 0;
        for (int i = 0; i < 150; i++) begin
            cyc(0, 1, 4'd1, 1, 0, 0, sat8(c),     4'd3,  1, "sat_up1");
            cyc(0, 1, 4'd3, 1, 0, 0, sat8(c),     4'd5,  1, "sat_up3");
            cyc(0, 1, 4'd5, 1, 1, 0, sat8(c),     4'd7,  1, "sat_lock");
            cyc(0, 1, 4'd0, 1, 1, 1, sat8(c + 1), 4'd9,  1, "sat_miss1");
            cyc(0, 1, 4'd0, 1, 0, 1, sat8(c + 2), 4'd11, 1, "sat_miss2");
            c = c + 2;
        end
        cyc(0, 1, 4'd1,  1, 0, 0, 8'd255, 4'd3,  1, "sat_final_up1");
        cyc(0, 1, 4'd3,  1, 0, 0, 8'd255, 4'd5,  1, "sat_final_up3");
        cyc(0, 1, 4'd5,  1, 1, 0, 8'd255, 4'd7,  1, "sat_final_lock");

        // Reset wins over a valid sample while locked.
        cyc(1, 1, 4'd7,  1, 0, 0, 8'd0,   4'd1,  1, "reset_while_locked");
        cyc(0, 1, 4'd3,  0, 0, 0, 8'd0,   4'd1,  0, "post_reset_hunt");

        reset = 1'b0;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        done = 1'b1;
        if (n_bad != 0) begin
            $display("FAIL summary: %0d mismatches", n_bad);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
